// File: rtl/imem_byte_loader.sv
// Streams bytes from a valid/ready source into instruction memory, one write per accepted byte,
// and freezes the CPU fetch path (cpu_hold) while a load session is in progress or has failed.
module imem_byte_loader #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   byte_count
);

  typedef enum logic [1:0] {StIdle, StLoad, StFinish, StErr} state_t;

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  // Index of the last byte that still fits below DEPTH when starting at BASE_ADDR.
  localparam logic [ADDR_WIDTH:0]   MaxIdx   = (ADDR_WIDTH+1)'(DEPTH - BASE_ADDR - 1);

  state_t state;
  logic   accept;

  assign accept = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BaseAddr;
      mem_data   <= 8'h00;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      byte_count <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;

      if (accept) begin
        mem_we     <= 1'b1;
        mem_data   <= byte_in;
        mem_addr   <= BaseAddr + byte_count[ADDR_WIDTH-1:0];
        byte_count <= byte_count + 1'b1;
      end

      unique case (state)
        StIdle, StErr: begin
          if (start) begin
            state      <= StLoad;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            byte_count <= '0;
            error      <= 1'b0;
            mem_addr   <= BaseAddr;
          end
        end
        StLoad: begin
          if (accept) begin
            if (byte_last) begin
              state      <= StFinish;
              byte_ready <= 1'b0;
            end else if (byte_count == MaxIdx) begin
              // Memory is full and the image did not end: overflow.
              state      <= StErr;
              byte_ready <= 1'b0;
              error      <= 1'b1;
            end
          end
        end
        StFinish: begin
          // byte_count already includes the last byte; images are whole instructions.
          if (byte_count[1:0] == 2'b00) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= StIdle;
          end else begin
            error <= 1'b1;
            state <= StErr;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_byte_loader.sv
// Scoreboard bench for imem_byte_loader: the driver queues the expected write for every accepted
// byte and a negedge monitor pops and compares each memory write.
module tb_imem_byte_loader;

  logic       clk = 1'b0;
  logic       reset, start, byte_valid, byte_last;
  logic [7:0] byte_in;
  logic       byte_ready, mem_we, cpu_hold, done, error;
  logic [8:0] mem_addr;
  logic [7:0] mem_data;
  logic [9:0] byte_count;

  imem_byte_loader #(.ADDR_WIDTH(9), .DEPTH(512), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .cpu_hold(cpu_hold), .done(done), .error(error),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] addr;
    logic [7:0] data;
    int         idx;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         errors = 0;
  int         sess_idx = 0;
  int         done_cnt = 0;
  int         cyc = 0;
  int         first_we_cyc = -1;
  int         last_we_cyc = -1;
  logic [7:0] shadow [512];
  logic [7:0] prog [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'(k) ^ 8'h5a;
  endfunction

  // Monitor: every write must match the oldest accepted byte.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (done) done_cnt++;
    if (mem_we) begin
      if (expq.size() == 0) begin
        check("spurious_we", 32'(mem_addr), 32'hffff_ffff);
      end else begin
        e = expq.pop_front();
        check("we_addr", 32'(mem_addr), 32'(e.addr));
        check("we_data", 32'(mem_data), 32'(e.data));
        check("we_count", 32'(byte_count), 32'(e.idx + 1));
        check("we_hold", 32'(cpu_hold), 32'd1);
      end
      shadow[mem_addr] = mem_data;
      if (first_we_cyc < 0) first_we_cyc = cyc;
      last_we_cyc = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input int gap,
                           output logic acc);
    int t;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_in = d; byte_last = last; byte_valid = 1'b1; t = 0;
    while (!byte_ready && t < 20) begin @(posedge clk); #1; t++; end
    acc = byte_ready;
    if (acc) begin
      expq.push_back('{addr: 9'(sess_idx), data: d, idx: sess_idx});
      sess_idx++;
    end
    @(posedge clk); #1;
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sess_idx = 0; done_cnt = 0; first_we_cyc = -1; last_we_cyc = -1;
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_ready", 32'(byte_ready), 32'd1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_empty", 32'(expq.size()), 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_count", 32'(byte_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got %0d want 0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    prog[0] = 8'h24; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h05;
    prog[4] = 8'h00; prog[5] = 8'h00; prog[6] = 8'h00; prog[7] = 8'h00;
    for (int i = 0; i < 512; i++) shadow[i] = 8'hxx;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; byte_in = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;

    // 1: back-to-back 8-byte image.
    do_start();
    for (int k = 0; k < 8; k++) begin
      send_byte(prog[k], k == 7, 0, acc);
      check("t1_acc", 32'(acc), 32'd1);
    end
    settle();
    check("t1_done", 32'(done_cnt), 32'd1);
    check("t1_count", 32'(byte_count), 32'd8);
    check("t1_error", 32'(error), 32'd0);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_back2back", 32'(last_we_cyc - first_we_cyc), 32'd7);

    // 2: same image with valid toggled.
    for (int i = 0; i < 8; i++) shadow[i] = 8'hxx;
    do_start();
    for (int k = 0; k < 8; k++) begin
      send_byte(prog[k], k == 7, 1, acc);
      check("t2_acc", 32'(acc), 32'd1);
    end
    settle();
    for (int i = 0; i < 8; i++) check("t2_mem", 32'(shadow[i]), 32'(prog[i]));
    check("t2_done", 32'(done_cnt), 32'd1);
    check("t2_count", 32'(byte_count), 32'd8);

    // 3: misaligned length.
    do_start();
    for (int k = 0; k < 6; k++) begin
      send_byte(pat(k), k == 5, 0, acc);
      check("t3_acc", 32'(acc), 32'd1);
    end
    settle();
    check("t3_error", 32'(error), 32'd1);
    check("t3_done", 32'(done_cnt), 32'd0);
    check("t3_hold", 32'(cpu_hold), 32'd1);
    check("t3_ready", 32'(byte_ready), 32'd0);
    check("t3_count", 32'(byte_count), 32'd6);

    // 4a: overflow, restarted from the error state.
    do_start();
    check("t4_err_clr", 32'(error), 32'd0);
    for (int k = 0; k < 512; k++) begin
      send_byte(pat(k), 1'b0, 0, acc);
      if (!acc) check("t4_acc", 32'(k), 32'd512);
    end
    send_byte(8'hee, 1'b0, 0, acc);
    check("t4_no_513", 32'(acc), 32'd0);
    settle();
    check("t4_error", 32'(error), 32'd1);
    check("t4_count", 32'(byte_count), 32'd512);
    check("t4_hold", 32'(cpu_hold), 32'd1);
    check("t4_mem511", 32'(shadow[511]), 32'(pat(511)));
    check("t4_done", 32'(done_cnt), 32'd0);

    // 4b: full-size image ending exactly on the last byte.
    do_start();
    for (int k = 0; k < 512; k++) begin
      send_byte(pat(k + 3), k == 511, 0, acc);
      if (!acc) check("t4b_acc", 32'(k), 32'd512);
    end
    settle();
    check("t4b_done", 32'(done_cnt), 32'd1);
    check("t4b_error", 32'(error), 32'd0);
    check("t4b_count", 32'(byte_count), 32'd512);
    check("t4b_mem0", 32'(shadow[0]), 32'(pat(3)));

    // 5: reset while the third byte is offered.
    do_start();
    send_byte(8'hc1, 1'b0, 0, acc);
    send_byte(8'hc2, 1'b0, 0, acc);
    byte_in = 8'hc3; byte_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    check_reset_vals();
    check("t5_mem0", 32'(shadow[0]), 32'hc1);
    check("t5_mem1", 32'(shadow[1]), 32'hc2);
    check("t5_queue", 32'(expq.size()), 32'd0);
    @(posedge clk); #1;
    do_start();
    for (int k = 0; k < 4; k++) begin
      send_byte(pat(k + 9), k == 3, 0, acc);
      check("t5_acc", 32'(acc), 32'd1);
    end
    settle();
    check("t5_done", 32'(done_cnt), 32'd1);
    check("t5_count", 32'(byte_count), 32'd4);

    // 6: start during LOAD is ignored.
    do_start();
    send_byte(8'h11, 1'b0, 0, acc);
    send_byte(8'h22, 1'b0, 0, acc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t6_count_hold", 32'(byte_count), 32'd2);
    send_byte(8'h33, 1'b0, 0, acc);
    send_byte(8'h44, 1'b1, 0, acc);
    settle();
    check("t6_done", 32'(done_cnt), 32'd1);
    check("t6_count", 32'(byte_count), 32'd4);
    check("t6_error", 32'(error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
